// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing source. Divides clk down to a one-clk pixel strobe
//   and advances the column/line counters. Sync, bright and the line/frame
//   strobes are registered on the same clk as the counters, so they always
//   line up with the hCount/vCount they describe.
//   Optional feature: define VGA_FRAME_CNT_EN to add the 16-bit frameCount
//   output, which counts frameStart pulses.
//   Parameter ranges: CLK_DIV 1..16; H_TOTAL and V_TOTAL each <= 1024.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int CLK_DIV   = 2,
   parameter bit SYNC_POL  = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   output logic        pixEn,
   output logic [9:0]  hCount,
   output logic [9:0]  vCount,
   output logic        hSync,
   output logic        vSync,
   output logic        bright,
   output logic        lineStart,
   output logic        frameStart
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [15:0] frameCount
`endif
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
   localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic       SYNC_ON  = SYNC_POL;
   localparam logic       SYNC_OFF = ~SYNC_POL;

   logic [3:0] div_cnt;
   logic       pix_tick;
   logic       h_wrap;
   logic       v_wrap;
   logic [9:0] h_next;
   logic [9:0] v_next;
   logic       hsync_next;
   logic       vsync_next;
   logic       bright_next;

   // Next raster position and the sync/bright levels that belong to it.
   always_comb begin
      // NOTE: every always_comb output is given a default first, so no path can leave a latch behind.
      pix_tick    = 1'b0;
      h_wrap      = 1'b0;
      v_wrap      = 1'b0;
      h_next      = hCount;
      v_next      = vCount;
      hsync_next  = SYNC_OFF;
      vsync_next  = SYNC_OFF;
      bright_next = 1'b0;

      pix_tick = en && (div_cnt == DIV_LAST);
      h_wrap   = (hCount == H_LAST);
      v_wrap   = (vCount == V_LAST);

      h_next = h_wrap ? 10'd0 : hCount + 10'd1;
      if (h_wrap) begin
         v_next = v_wrap ? 10'd0 : vCount + 10'd1;
      end

      if (h_next >= H_SYNC_FIRST && h_next <= H_SYNC_LAST) begin
         hsync_next = SYNC_ON;
      end
      if (v_next >= V_SYNC_FIRST && v_next <= V_SYNC_LAST) begin
         vsync_next = SYNC_ON;
      end
      bright_next = (h_next < H_VIS_END) && (v_next < V_VIS_END);
   end

   // Clock divider: counts enabled clks and wraps once per pixel period.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses <= so every register sees the values from before the edge.
      if (reset) begin
         div_cnt <= '0;
      end else if (en) begin
         div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
      end
   end

   // Raster counters and their level outputs advance together on each pixel strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hCount <= H_LAST;
         vCount <= V_LAST;
         hSync  <= SYNC_OFF;
         vSync  <= SYNC_OFF;
         bright <= 1'b0;
      end else if (pix_tick) begin
         hCount <= h_next;
         vCount <= v_next;
         hSync  <= hsync_next;
         vSync  <= vsync_next;
         bright <= bright_next;
      end
   end

   // One-clk strobes; all drop to 0 whenever en is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pixEn      <= 1'b0;
         lineStart  <= 1'b0;
         frameStart <= 1'b0;
      end else begin
         pixEn      <= pix_tick;
         lineStart  <= pix_tick && h_wrap;
         frameStart <= pix_tick && h_wrap && v_wrap;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   // Frame counter: steps on the same clk that frameStart is raised, wraps at 0xFFFF.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frameCount <= '0;
      end else if (pix_tick && h_wrap && v_wrap) begin
         frameCount <= frameCount + 16'd1;
      end
   end
`endif

endmodule
